// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the instruction encoder.
// Holds the opcode constants, the canonical NOP word, the instruction format
// enumeration and a helper that maps an opcode to its format.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_t;

  // Map an opcode onto the instruction format used to assemble it.
  function automatic fmt_t opcode_fmt(input logic [6:0] op);
    fmt_t f;
    case (op)
      OP_R:                             f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: f = FMT_I;
      OP_STORE:                         f = FMT_S;
      OP_BRANCH:                        f = FMT_B;
      OP_LUI, OP_AUIPC:                 f = FMT_U;
      OP_JAL:                           f = FMT_J;
      default:                          f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_format_pack.sv
// Purely combinational RV32I word assembler.
// Ports: opcode/rd/funct3/rs1/rs2/funct7/imm decoded fields in;
//        instr = assembled word, err = unsupported opcode or odd B/J offset.
module instr_format_pack
  import rv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_t fmt_s;
  assign fmt_s = opcode_fmt(opcode);

  // Field placement per instruction format.
  always_comb begin
    instr = NOP;
    err   = 1'b0;
    case (fmt_s)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if ((opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101))) begin
          instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        end else begin
          instr = {imm[11:0], rs1, funct3, rd, opcode};
        end
      end
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = imm[0];
      end
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = imm[0];
      end
      default: begin
        instr = NOP;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder for the program-loader path.
// Ports: clk/reset_n; input handshake in_valid/in_ready/in_last with fields
//        opcode, rd, funct3, rs1, rs2, funct7, imm; output handshake
//        out_valid/out_ready with out_instr, out_addr, out_err; status flags
//        err_sticky, done (one-cycle pulse on last transfer), wrapped.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int unsigned             ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic              done,
  output logic              wrapped
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic              sticky_q, sticky_d;
  logic              done_q, done_d;
  logic              wrapped_q, wrapped_d;

  logic [31:0] pack_instr_s;
  logic        pack_err_s;
  logic        accept_s;
  logic        xfer_s;

  instr_format_pack u_pack (
    .opcode (opcode),
    .rd     (rd),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct7 (funct7),
    .imm    (imm),
    .instr  (pack_instr_s),
    .err    (pack_err_s)
  );

  assign out_valid  = (state_q == ST_FULL);
  // Combinational from out_ready so a draining word frees the slot in the same cycle.
  assign in_ready   = !out_valid || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign xfer_s     = out_valid && out_ready;
  assign out_instr  = instr_q;
  assign out_addr   = addr_q;
  assign out_err    = err_q;
  assign err_sticky = sticky_q;
  assign done       = done_q;
  assign wrapped    = wrapped_q;

  // Next-state for the output stage, address counter and status flags.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    err_d     = err_q;
    last_d    = last_q;
    sticky_d  = sticky_q;
    done_d    = 1'b0;
    wrapped_d = wrapped_q;

    if (xfer_s) begin
      sticky_d = sticky_q | err_q;
      if (last_q) begin
        // Program finished: restart addressing for the next program.
        addr_d    = BASE_ADDR;
        wrapped_d = 1'b0;
        done_d    = 1'b1;
      end else begin
        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (addr_q == {ADDR_W{1'b1}}) begin
          wrapped_d = 1'b1;
        end else begin
          wrapped_d = wrapped_q;
        end
      end
    end else begin
      sticky_d = sticky_q;
    end

    if (accept_s) begin
      instr_d = pack_instr_s;
      err_d   = pack_err_s;
      last_d  = in_last;
    end else begin
      instr_d = instr_q;
    end

    case (state_q)
      ST_EMPTY: begin
        if (accept_s) state_d = ST_FULL;
        else          state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (xfer_s && !accept_s) state_d = ST_EMPTY;
        else                     state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register; reset discards any held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      instr_q   <= 32'h00000000;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      last_q    <= last_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_last;
  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid, out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err, err_sticky, done, wrapped;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(2'd0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .opcode     (opcode),
    .rd         (rd),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct7     (funct7),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .done       (done),
    .wrapped    (wrapped)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] golden;
    logic        err;
    logic        last;
  } ent_t;

  ent_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          m_addr = 0;
  bit          m_sticky = 1'b0;
  bit          m_wrapped = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] golden_next = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from shifts and masks of the field values.
  function automatic void ref_encode(input int unsigned op, input int unsigned rdv,
                                     input int unsigned f3, input int unsigned r1,
                                     input int unsigned r2, input int unsigned f7,
                                     input int unsigned iv,
                                     output logic [31:0] w, output logic e);
    int unsigned base;
    base = (r1 << 15) | (f3 << 12);
    e = 1'b0;
    case (op)
      32'h33: w = (f7 << 25) | (r2 << 20) | base | (rdv << 7) | op;
      32'h13, 32'h03, 32'h67, 32'h73: begin
        if (op == 32'h13 && (f3 == 1 || f3 == 5))
          w = (f7 << 25) | ((iv & 31) << 20) | base | (rdv << 7) | op;
        else
          w = ((iv & 32'hFFF) << 20) | base | (rdv << 7) | op;
      end
      32'h23: w = (((iv >> 5) & 127) << 25) | (r2 << 20) | base | ((iv & 31) << 7) | op;
      32'h63: begin
        w = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 63) << 25) | (r2 << 20) | base |
            (((iv >> 1) & 15) << 8) | (((iv >> 11) & 1) << 7) | op;
        e = (iv & 1) != 0;
      end
      32'h37, 32'h17: w = (iv & 32'hFFFFF000) | (rdv << 7) | op;
      32'h6F: begin
        w = (((iv >> 20) & 1) << 31) | (((iv >> 1) & 1023) << 21) | (((iv >> 11) & 1) << 20) |
            (((iv >> 12) & 255) << 12) | (rdv << 7) | op;
        e = (iv & 1) != 0;
      end
      default: begin
        w = 32'h00000013;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic drive(input bit v, input int unsigned op, input int unsigned rdv,
                       input int unsigned f3, input int unsigned r1, input int unsigned r2,
                       input int unsigned f7, input int unsigned iv, input bit last, input bit ordy);
    in_valid  = v;
    opcode    = op[6:0];
    rd        = rdv[4:0];
    funct3    = f3[2:0];
    rs1       = r1[4:0];
    rs2       = r2[4:0];
    funct7    = f7[6:0];
    imm       = iv;
    in_last   = last;
    out_ready = ordy;
  endtask

  // One clock: check at negedge, advance the model at posedge, return #1 after.
  task automatic cycle(input string tag);
    bit   xfer, acc;
    ent_t e;
    @(negedge clk);
    chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, q.size() != 0});
    chk({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, (q.size() == 0) || out_ready});
    chk({tag, ".out_addr"}, {30'h0, out_addr}, m_addr);
    chk({tag, ".err_sticky"}, {31'h0, err_sticky}, {31'h0, m_sticky});
    chk({tag, ".wrapped"}, {31'h0, wrapped}, {31'h0, m_wrapped});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, m_done});
    if (q.size() != 0) begin
      chk({tag, ".out_instr"}, out_instr, q[0].instr);
      chk({tag, ".out_err"}, {31'h0, out_err}, {31'h0, q[0].err});
      if (q[0].golden != 32'h0) chk({tag, ".golden"}, out_instr, q[0].golden);
    end
    xfer = (q.size() != 0) && out_ready;
    acc  = in_valid && ((q.size() == 0) || out_ready);
    @(posedge clk);
    m_done = 1'b0;
    if (xfer) begin
      e = q.pop_front();
      if (e.err) m_sticky = 1'b1;
      if (e.last) begin
        m_addr = 0;
        m_wrapped = 1'b0;
        m_done = 1'b1;
      end else begin
        m_addr = (m_addr + 1) % (1 << AW);
        if (m_addr == 0) m_wrapped = 1'b1;
      end
    end
    if (acc) begin
      ref_encode(opcode, rd, funct3, rs1, rs2, funct7, imm, e.instr, e.err);
      e.last   = in_last;
      e.golden = golden_next;
      q.push_back(e);
      golden_next = 32'h0;
    end
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_addr = 0;
    m_sticky = 1'b0;
    m_wrapped = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  int unsigned ops[12] = '{32'h33, 32'h13, 32'h03, 32'h67, 32'h73, 32'h23,
                           32'h63, 32'h37, 32'h17, 32'h6F, 32'h7F, 32'h0B};

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    do_reset();

    // Reset state
    @(negedge clk);
    chk("reset.out_instr", out_instr, 32'h00000000);
    cycle("reset");

    // add x3,x1,x2
    drive(1'b1, 32'h33, 3, 0, 1, 2, 0, 0, 1'b0, 1'b1);
    golden_next = 32'h002081B3;
    cycle("add");
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("add_out");
    cycle("add_idle");

    // Back-to-back stream from a fresh reset so addresses start at 0
    do_reset();
    drive(1'b1, 32'h13, 1, 0, 0, 0, 0, 5, 1'b0, 1'b1);
    golden_next = 32'h00500093;
    cycle("addi");
    drive(1'b1, 32'h23, 0, 2, 1, 2, 0, 8, 1'b0, 1'b1);
    golden_next = 32'h0020A423;
    cycle("sw");
    drive(1'b1, 32'h63, 0, 0, 1, 2, 0, 32'hFFFFFFFC, 1'b0, 1'b1);
    golden_next = 32'hFE208EE3;
    cycle("beq");
    drive(1'b1, 32'h6F, 1, 0, 0, 0, 0, 2048, 1'b0, 1'b1);
    golden_next = 32'h001000EF;
    cycle("jal");
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("stream_drain");
    cycle("stream_idle");

    // Backpressure hold, then simultaneous transfer + accept
    drive(1'b1, 32'h37, 5, 0, 0, 0, 0, 32'hABCDE123, 1'b0, 1'b0);
    cycle("hold_acc");
    drive(1'b1, 32'h13, 7, 1, 3, 0, 32, 9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("hold");
    out_ready = 1'b1;
    cycle("hold_release");
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("hold_drain");
    cycle("hold_idle");

    // Bad opcode then misaligned branch
    drive(1'b1, 32'h7F, 1, 0, 2, 3, 0, 0, 1'b0, 1'b1);
    cycle("badop");
    drive(1'b1, 32'h63, 0, 1, 4, 5, 0, 3, 1'b0, 1'b1);
    cycle("misalign");
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("err_drain");
    cycle("err_idle");

    // Address wrap and last handling
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h33, i, 0, i, i, 0, 0, i == 4, 1'b1);
      cycle("wrap_seq");
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("wrap_drain");
    drive(1'b1, 32'h17, 9, 0, 0, 0, 0, 32'h12345000, 1'b0, 1'b1);
    cycle("after_done");
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("after_done_out");
    cycle("after_done_idle");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 11)], $urandom_range(0, 31),
            $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 127), $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0);
      cycle("rand");
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("rand_drain");
    cycle("rand_idle");

    // Asynchronous reset while FULL and stalled
    drive(1'b1, 32'h33, 1, 0, 1, 1, 0, 0, 1'b1, 1'b0);
    cycle("rst_fill");
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    cycle("rst_full");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst.out_addr", {30'h0, out_addr}, 32'h0);
    chk("async_rst.done", {31'h0, done}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    cycle("post_rst");
    cycle("post_rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
